// File: rtl/inert_pkg.sv
// inert_pkg: shared state encoding, init command table and SPI read-command
// helper for the inertial sensor sequencer.
package inert_pkg;

    typedef enum logic [1:0] {WAKE, INIT, WAIT_INT, READ} state_t;

    // Entry 0 is issued first.
    localparam logic [3:0][15:0] INIT_TBL = {16'h1460, 16'h1150, 16'h1053, 16'h0D02};

    function automatic logic [15:0] rd_cmd(input logic [6:0] addr);
        return {1'b1, addr, 8'h00};
    endfunction

endpackage

// File: rtl/int_sync_edge.sv
// int_sync_edge: two-flop synchronizer for an asynchronous level with a
// third flop providing a one-cycle rising-edge pulse.
module int_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic sync,
    output logic rise
);

    logic s1, s2, s3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= d;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign sync = s2;
    assign rise = s2 & ~s3;

endmodule

// File: rtl/inert_seq_mc.sv
// inert_seq_mc: wakes and initialises an inertial sensor over SPI, then reads
// NUM_CH 16-bit channels per interrupt and publishes them atomically.
module inert_seq_mc
    import inert_pkg::*;
#(
    parameter int               NUM_CH    = 2,
    parameter logic [NUM_CH*8-1:0] CH_BASE = {8'h2C, 8'h22},
    parameter int               WAKE_BITS = 16,
    parameter int               TO_BITS   = 20
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   INT,
    input  logic                   clr_err,
    input  logic                   done,
    input  logic [15:0]            rd_data,
    output logic                   wrt,
    output logic [15:0]            cmd,
    output logic [NUM_CH*16-1:0]   ch_data,
    output logic                   vld,
    output logic                   err,
    output logic                   ovr,
    output logic                   busy
);

    localparam int         NB     = 2 * NUM_CH;
    localparam logic [3:0] K_LAST = 4'(NB - 1);

    state_t                 state, state_nx;
    logic [WAKE_BITS-1:0]   wake_cnt, wake_nx;
    logic [TO_BITS-1:0]     to_cnt, to_nx;
    logic [1:0]             idx, idx_nx;
    logic [3:0]             k, k_nx;
    logic [NUM_CH*16-1:0]   shadow, shadow_nx, ch_nx;
    logic [15:0]            cmd_nx;
    logic                   wrt_nx, vld_nx, err_nx, ovr_nx;
    logic                   err_set, ovr_set;
    logic                   rise;
    logic                   unused_sync, unused_hi;

    int_sync_edge u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (INT),
        .sync  (unused_sync),
        .rise  (rise)
    );

    assign unused_hi = ^rd_data[15:8];

    // Byte kk lives at CH_BASE of channel kk/2, plus one for the high byte.
    function automatic logic [6:0] ch_addr(input logic [3:0] kk);
        logic [7:0] base;
        base = '0;
        for (int i = 0; i < NUM_CH; i++)
            if (kk[3:1] == 3'(i)) base = CH_BASE[i*8+:8];
        return 7'(base + {7'd0, kk[0]});
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= WAKE;
            wake_cnt <= '0;
            to_cnt   <= '0;
            idx      <= '0;
            k        <= '0;
            shadow   <= '0;
            ch_data  <= '0;
            cmd      <= '0;
            wrt      <= 1'b0;
            vld      <= 1'b0;
            err      <= 1'b0;
            ovr      <= 1'b0;
        end else begin
            state    <= state_nx;
            wake_cnt <= wake_nx;
            to_cnt   <= to_nx;
            idx      <= idx_nx;
            k        <= k_nx;
            shadow   <= shadow_nx;
            ch_data  <= ch_nx;
            cmd      <= cmd_nx;
            wrt      <= wrt_nx;
            vld      <= vld_nx;
            err      <= err_nx;
            ovr      <= ovr_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        wake_nx   = wake_cnt;
        to_nx     = to_cnt;
        idx_nx    = idx;
        k_nx      = k;
        shadow_nx = shadow;
        ch_nx     = ch_data;
        cmd_nx    = cmd;
        wrt_nx    = 1'b0;
        vld_nx    = 1'b0;
        err_set   = 1'b0;
        ovr_set   = 1'b0;
        case (state)
            WAKE: begin
                if (&wake_cnt) begin
                    wrt_nx   = 1'b1;
                    cmd_nx   = INIT_TBL[0];
                    idx_nx   = '0;
                    state_nx = INIT;
                end else begin
                    wake_nx = wake_cnt + 1'b1;
                end
            end
            INIT: begin
                if (done) begin
                    if (idx != 2'd3) begin
                        idx_nx = idx + 2'd1;
                        wrt_nx = 1'b1;
                        cmd_nx = INIT_TBL[idx + 2'd1];
                    end else begin
                        to_nx    = '0;
                        state_nx = WAIT_INT;
                    end
                end
            end
            WAIT_INT: begin
                if (rise) begin
                    wrt_nx   = 1'b1;
                    cmd_nx   = rd_cmd(ch_addr(4'd0));
                    k_nx     = '0;
                    state_nx = READ;
                end else if (&to_cnt) begin
                    // Preset so the init table restarts on the very next cycle.
                    err_set  = 1'b1;
                    wake_nx  = '1;
                    state_nx = WAKE;
                end else begin
                    to_nx = to_cnt + 1'b1;
                end
            end
            READ: begin
                ovr_set = rise;
                if (done) begin
                    for (int j = 0; j < NB; j++)
                        if (k == 4'(j)) shadow_nx[j*8+:8] = rd_data[7:0];
                    if (k != K_LAST) begin
                        k_nx   = k + 4'd1;
                        wrt_nx = 1'b1;
                        cmd_nx = rd_cmd(ch_addr(k + 4'd1));
                    end else begin
                        ch_nx    = shadow_nx;
                        vld_nx   = 1'b1;
                        to_nx    = '0;
                        state_nx = WAIT_INT;
                    end
                end
            end
            default: state_nx = WAKE;
        endcase
        err_nx = err_set | (err & ~clr_err);
        ovr_nx = ovr_set | (ovr & ~clr_err);
    end

    assign busy = (state != WAIT_INT);

endmodule

// File: tb/tb_inert_seq_mc.sv
// tb_inert_seq_mc: scoreboard bench; an SPI slave model answers wrt after a
// fixed latency from a byte map, monitors compare cmd and ch_data to queues.
module tb_inert_seq_mc;

    localparam int NUM_CH = 3;
    localparam int LAT    = 20;

    logic                 clk     = 1'b0;
    logic                 rst_n   = 1'b1;
    logic                 INT     = 1'b0;
    logic                 clr_err = 1'b0;
    logic                 done    = 1'b0;
    logic [15:0]          rd_data = '0;
    logic                 wrt;
    logic [15:0]          cmd;
    logic [NUM_CH*16-1:0] ch_data;
    logic                 vld, err, ovr, busy;

    always #5 clk = ~clk;

    inert_seq_mc #(
        .NUM_CH    (NUM_CH),
        .CH_BASE   ({8'h28, 8'h2C, 8'h22}),
        .WAKE_BITS (4),
        .TO_BITS   (6)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .INT     (INT),
        .clr_err (clr_err),
        .done    (done),
        .rd_data (rd_data),
        .wrt     (wrt),
        .cmd     (cmd),
        .ch_data (ch_data),
        .vld     (vld),
        .err     (err),
        .ovr     (ovr),
        .busy    (busy)
    );

    int vectors = 0, miscompares = 0;
    int wrt_cnt = 0, vld_cnt = 0, done_cnt = 0;
    logic [15:0]          exp_cmd[$];
    logic [NUM_CH*16-1:0] exp_ch[$];
    logic [NUM_CH*16-1:0] last_ch = '0;
    logic [7:0]           regmem[128];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // SPI slave: done pulses LAT cycles after wrt, returning regmem[addr].
    int pend = 0;
    logic [6:0] cur = '0;
    always @(negedge clk) begin
        if (!rst_n) begin
            pend = 0;
            done = 1'b0;
        end else begin
            done = 1'b0;
            if (pend != 0) begin
                pend--;
                if (pend == 0) begin
                    done    = 1'b1;
                    rd_data = {8'h00, regmem[cur]};
                    done_cnt++;
                end
            end
            if (wrt) begin
                pend = LAT;
                cur  = cmd[14:8];
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            if (wrt) begin
                wrt_cnt++;
                if (exp_cmd.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_wrt: got cmd %0h expected no wrt", cmd);
                end else check("cmd", cmd, exp_cmd.pop_front());
            end
            if (vld) begin
                vld_cnt++;
                check("vld_after_done", done, 1);
                if (exp_ch.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_vld: got ch_data %0h expected no vld", ch_data);
                end else check("ch_data", ch_data, exp_ch.pop_front());
            end else if (ch_data !== last_ch) begin
                miscompares++;
                $display("FAIL ch_data_stable: got %0h expected %0h", ch_data, last_ch);
            end
        end
        last_ch = ch_data;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wait_busy(input logic val, input string name);
        int c = 0;
        while (busy !== val && c < 2000) begin
            tick(1);
            c++;
        end
        check(name, busy, val);
    endtask

    task automatic wait_vld(input int n, input string name);
        int c = 0;
        while (vld_cnt < n && c < 2000) begin
            tick(1);
            c++;
        end
        check(name, vld_cnt, n);
    endtask

    task automatic wait_done(input int n);
        int c = 0;
        while (done_cnt < n && c < 2000) begin
            tick(1);
            c++;
        end
        check("done_seen", done_cnt, n);
    endtask

    task automatic push_init();
        exp_cmd.push_back(16'h0D02);
        exp_cmd.push_back(16'h1053);
        exp_cmd.push_back(16'h1150);
        exp_cmd.push_back(16'h1460);
    endtask

    task automatic push_read();
        exp_cmd.push_back(16'hA200);
        exp_cmd.push_back(16'hA300);
        exp_cmd.push_back(16'hAC00);
        exp_cmd.push_back(16'hAD00);
        exp_cmd.push_back(16'hA800);
        exp_cmd.push_back(16'hA900);
    endtask

    task automatic set_bytes(input logic [47:0] b);
        regmem[7'h22] = b[7:0];
        regmem[7'h23] = b[15:8];
        regmem[7'h2C] = b[23:16];
        regmem[7'h2D] = b[31:24];
        regmem[7'h28] = b[39:32];
        regmem[7'h29] = b[47:40];
    endtask

    task automatic check_reset_vals();
        check("rst_wrt", wrt, 0);
        check("rst_cmd", cmd, 0);
        check("rst_ch_data", ch_data, 0);
        check("rst_vld", vld, 0);
        check("rst_err", err, 0);
        check("rst_ovr", ovr, 0);
        check("rst_busy", busy, 1);
    endtask

    task automatic pulse_int();
        INT = 1'b1;
        tick(3);
        INT = 1'b0;
    endtask

    initial begin
        int c;
        for (int i = 0; i < 128; i++) regmem[i] = 8'h00;
        set_bytes(48'h9ABC_5678_1234);
        #1 rst_n = 1'b0;
        tick(3);
        check_reset_vals();

        // Wake and init
        push_init();
        rst_n = 1'b1;
        wait_busy(0, "init_done");
        check("init_wrt_count", wrt_cnt, 4);

        // Default read burst
        push_read();
        exp_ch.push_back(48'h9ABC_5678_1234);
        pulse_int();
        wait_vld(1, "burst1_vld");
        tick(1);
        check("burst1_vld_single", vld, 0);
        check("burst1_idle", busy, 0);
        check("burst1_wrt_count", wrt_cnt, 10);

        // Overrun: second INT edge mid-burst
        set_bytes(48'h8001_DEAD_BEEF);
        push_read();
        exp_ch.push_back(48'h8001_DEAD_BEEF);
        pulse_int();
        wait_done(done_cnt + 2);
        pulse_int();
        wait_vld(2, "burst2_vld");
        tick(2);
        check("ovr_set", ovr, 1);
        tick(30);
        check("no_extra_read_busy", busy, 0);
        check("no_extra_read_wrt", wrt_cnt, 16);
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        check("ovr_cleared", ovr, 0);

        // clr_err in the same cycle as a new overrun edge
        push_read();
        exp_ch.push_back(48'h8001_DEAD_BEEF);
        pulse_int();
        wait_done(done_cnt + 2);
        INT = 1'b1;
        tick(2);
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        INT = 1'b0;
        check("ovr_set_wins", ovr, 1);
        wait_vld(3, "burst3_vld");

        // Timeout with no INT
        push_init();
        c = 0;
        while (err !== 1'b1 && c < 300) begin
            tick(1);
            c++;
        end
        check("err_set", err, 1);
        check("timeout_cycles_in_range", (c >= 63 && c <= 65), 1);
        wait_busy(0, "reinit_done");
        check("reinit_wrt_count", wrt_cnt, 26);
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        check("err_cleared", err, 0);
        check("ovr_cleared2", ovr, 0);

        // Reset during READ after two bytes
        push_read();
        pulse_int();
        wait_done(done_cnt + 2);
        tick(3);
        rst_n = 1'b0;
        exp_cmd.delete();
        tick(2);
        check_reset_vals();
        set_bytes(48'h9ABC_5678_1234);
        push_init();
        push_read();
        exp_ch.push_back(48'h9ABC_5678_1234);
        rst_n = 1'b1;
        wait_busy(0, "post_reset_init_done");
        pulse_int();
        wait_vld(4, "post_reset_vld");
        tick(2);
        check("final_ch_data", ch_data, 48'h9ABC_5678_1234);
        check("cmd_queue_drained", exp_cmd.size(), 0);
        check("ch_queue_drained", exp_ch.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
